// File: rtl/nand_seq_pkg.sv
// Shared encodings for the NAND operation sequencer: operations, engine cycle
// types, completion status, FSM states and the ONFI command bytes.
package nand_seq_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_PROGRAM = 2'd1,
    OP_ERASE   = 2'd2,
    OP_RESET   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    CYC_CMD   = 2'd0,
    CYC_ADDR  = 2'd1,
    CYC_WDATA = 2'd2,
    CYC_RDATA = 2'd3
  } cyc_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_FAIL    = 2'd1,
    ST_TIMEOUT = 2'd2
  } status_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD1,
    S_ADDR,
    S_WDATA,
    S_CMD2,
    S_TWB,
    S_WAIT_RB,
    S_STAT_CMD,
    S_STAT_RD,
    S_RDATA,
    S_DONE
  } state_e;

  localparam logic [7:0] CMD_READ1  = 8'h00;
  localparam logic [7:0] CMD_READ2  = 8'h30;
  localparam logic [7:0] CMD_PROG1  = 8'h80;
  localparam logic [7:0] CMD_PROG2  = 8'h10;
  localparam logic [7:0] CMD_ERASE1 = 8'h60;
  localparam logic [7:0] CMD_ERASE2 = 8'hD0;
  localparam logic [7:0] CMD_STATUS = 8'h70;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  localparam logic [2:0] ADDR_LAST        = 3'd4;
  // Erase addresses a block, so only the row bytes b2..b4 go out.
  localparam logic [2:0] ERASE_ADDR_FIRST = 3'd2;

  function automatic logic [7:0] first_cmd(input op_e op);
    case (op)
      OP_READ:    return CMD_READ1;
      OP_PROGRAM: return CMD_PROG1;
      OP_ERASE:   return CMD_ERASE1;
      default:    return CMD_RESET;
    endcase
  endfunction

  function automatic logic [7:0] second_cmd(input op_e op);
    case (op)
      OP_READ:    return CMD_READ2;
      OP_PROGRAM: return CMD_PROG2;
      default:    return CMD_ERASE2;
    endcase
  endfunction

endpackage

// File: rtl/nand_rb_sync.sv
// Ready/busy front end: two-flop synchroniser for the flash R/B# pin plus the
// post-command tWB delay counter and the busy-wait timeout counter.
module nand_rb_sync #(
  parameter int TWB_CYC     = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int TO_W        = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic f_nrb_i,
  input  logic twb_en_i,
  input  logic wait_en_i,
  output logic twb_done_o,
  output logic rb_ready_o,
  output logic rb_timeout_o
);

  // The cyc_done cycle counts as the first tWB cycle, so the wait state is
  // entered exactly TWB_CYC cycles after the last command completes.
  localparam logic [TO_W-1:0] TWB_LAST = TO_W'((TWB_CYC > 1) ? TWB_CYC - 2 : 0);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  logic [1:0]      sync_q;
  logic [TO_W-1:0] twb_cnt_q, twb_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    twb_cnt_d = '0;
    to_cnt_d  = '0;
    if (twb_en_i) begin
      twb_cnt_d = twb_cnt_q + 1'b1;
    end
    if (wait_en_i) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= 2'b00;
      twb_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      sync_q    <= {sync_q[0], f_nrb_i};
      twb_cnt_q <= twb_cnt_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign rb_ready_o   = sync_q[1];
  assign twb_done_o   = twb_en_i && (twb_cnt_q == TWB_LAST);
  assign rb_timeout_o = wait_en_i && (to_cnt_q == TO_LAST);

endmodule

// File: rtl/nand_op_sequencer.sv
// Expands one READ/PROGRAM/ERASE/RESET request into the command, address and
// data byte cycles for the flash-cycle engine, then busy-waits and reports status.
module nand_op_sequencer #(
  parameter int TWB_CYC     = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int TO_W        = 16
) (
  input  logic        P_clk,
  input  logic        P_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [39:0] req_addr,
  input  logic [7:0]  req_len,
  output logic        cyc_valid,
  output logic [1:0]  cyc_type,
  output logic [7:0]  cyc_byte,
  input  logic        cyc_done,
  input  logic [7:0]  cyc_rdata,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_pop,
  output logic [7:0]  rd_data,
  output logic        rd_push,
  input  logic        rd_ready,
  input  logic        F_nRB,
  output logic        busy,
  output logic        op_done,
  output logic [1:0]  op_status,
  output logic [7:0]  flash_status
);
  import nand_seq_pkg::*;

  state_e      state_q;
  op_e         op_q;
  logic [39:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  cnt_q;
  logic [2:0]  idx_q;
  logic        cyc_valid_q;
  cyc_e        cyc_type_q;
  logic [7:0]  cyc_byte_q;
  status_e     op_status_q;
  logic [7:0]  flash_status_q;

  logic        issue_en;
  cyc_e        issue_type;
  logic [7:0]  issue_byte;
  logic        cyc_fire;
  logic        twb_done, rb_ready, rb_timeout;

  function automatic logic [7:0] addr_byte(input logic [39:0] a, input logic [2:0] i);
    case (i)
      3'd0:    return a[7:0];
      3'd1:    return a[15:8];
      3'd2:    return a[23:16];
      3'd3:    return a[31:24];
      3'd4:    return a[39:32];
      default: return 8'h00;
    endcase
  endfunction

  nand_rb_sync #(
    .TWB_CYC     (TWB_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_rb_sync (
    .clk_i        (P_clk),
    .rst_i        (P_rst),
    .f_nrb_i      (F_nRB),
    .twb_en_i     (state_q == S_TWB),
    .wait_en_i    (state_q == S_WAIT_RB),
    .twb_done_o   (twb_done),
    .rb_ready_o   (rb_ready),
    .rb_timeout_o (rb_timeout)
  );

  // Cycle to present while no engine request is outstanding. Data cycles wait
  // on FIFO flow control; everything else issues right after the gap cycle.
  always_comb begin
    issue_en   = 1'b0;
    issue_type = CYC_CMD;
    issue_byte = 8'h00;
    case (state_q)
      S_CMD1: begin
        issue_en   = 1'b1;
        issue_byte = first_cmd(op_q);
      end
      S_ADDR: begin
        issue_en   = 1'b1;
        issue_type = CYC_ADDR;
        issue_byte = addr_byte(addr_q, idx_q);
      end
      S_WDATA: begin
        issue_en   = wr_valid;
        issue_type = CYC_WDATA;
        issue_byte = wr_data;
      end
      S_CMD2: begin
        issue_en   = 1'b1;
        issue_byte = second_cmd(op_q);
      end
      S_STAT_CMD: begin
        issue_en   = 1'b1;
        issue_byte = CMD_STATUS;
      end
      S_STAT_RD: begin
        issue_en   = 1'b1;
        issue_type = CYC_RDATA;
      end
      S_RDATA: begin
        issue_en   = rd_ready;
        issue_type = CYC_RDATA;
      end
      default: ;
    endcase
  end

  assign cyc_fire = cyc_valid_q && cyc_done;

  always_ff @(posedge P_clk) begin
    if (P_rst) begin
      state_q        <= S_IDLE;
      cyc_valid_q    <= 1'b0;
      cyc_type_q     <= CYC_CMD;
      cyc_byte_q     <= 8'h00;
      op_status_q    <= ST_OK;
      flash_status_q <= 8'h00;
    end else begin
      // A completed cycle always drops valid for one cycle before the next.
      if (cyc_fire) begin
        cyc_valid_q <= 1'b0;
      end else if (!cyc_valid_q && issue_en) begin
        cyc_valid_q <= 1'b1;
        cyc_type_q  <= issue_type;
        cyc_byte_q  <= issue_byte;
      end

      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q        <= op_e'(req_op);
            addr_q      <= req_addr;
            len_q       <= req_len;
            cnt_q       <= req_len;
            idx_q       <= (op_e'(req_op) == OP_ERASE) ? ERASE_ADDR_FIRST : 3'd0;
            state_q     <= S_CMD1;
            cyc_valid_q <= 1'b1;
            cyc_type_q  <= CYC_CMD;
            cyc_byte_q  <= first_cmd(op_e'(req_op));
          end
        end
        S_CMD1: begin
          if (cyc_fire) begin
            state_q <= (op_q == OP_RESET) ? S_TWB : S_ADDR;
          end
        end
        S_ADDR: begin
          if (cyc_fire) begin
            if (idx_q == ADDR_LAST) begin
              state_q <= (op_q == OP_PROGRAM && len_q != 8'd0) ? S_WDATA : S_CMD2;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        S_WDATA: begin
          if (cyc_fire) begin
            cnt_q <= cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              state_q <= S_CMD2;
            end
          end
        end
        S_CMD2: begin
          if (cyc_fire) begin
            state_q <= S_TWB;
          end
        end
        S_TWB: begin
          if (twb_done) begin
            state_q <= S_WAIT_RB;
          end
        end
        S_WAIT_RB: begin
          if (rb_ready) begin
            case (op_q)
              OP_READ: begin
                if (len_q == 8'd0) begin
                  state_q     <= S_DONE;
                  op_status_q <= ST_OK;
                end else begin
                  state_q <= S_RDATA;
                end
              end
              OP_RESET: begin
                state_q     <= S_DONE;
                op_status_q <= ST_OK;
              end
              default: state_q <= S_STAT_CMD;
            endcase
          end else if (rb_timeout) begin
            state_q     <= S_DONE;
            op_status_q <= ST_TIMEOUT;
          end
        end
        S_STAT_CMD: begin
          if (cyc_fire) begin
            state_q <= S_STAT_RD;
          end
        end
        S_STAT_RD: begin
          if (cyc_fire) begin
            flash_status_q <= cyc_rdata;
            op_status_q    <= cyc_rdata[0] ? ST_FAIL : ST_OK;
            state_q        <= S_DONE;
          end
        end
        S_RDATA: begin
          if (cyc_fire) begin
            cnt_q <= cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              state_q     <= S_DONE;
              op_status_q <= ST_OK;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign op_done      = (state_q == S_DONE);
  assign cyc_valid    = cyc_valid_q;
  assign cyc_type     = cyc_type_q;
  assign cyc_byte     = cyc_byte_q;
  assign op_status    = op_status_q;
  assign flash_status = flash_status_q;
  // FIFO strobes coincide with cyc_done so the Tx head has advanced before the
  // next WDATA cycle samples it.
  assign wr_pop       = cyc_fire && (state_q == S_WDATA);
  assign rd_push      = cyc_fire && (state_q == S_RDATA);
  assign rd_data      = rd_push ? cyc_rdata : 8'h00;

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Scoreboard bench for nand_op_sequencer: engine, Tx/Rx FIFO and R/B# models.
module tb_nand_op_sequencer;
  import nand_seq_pkg::*;

  localparam int TWB = 4;
  localparam int TMO = 300;
  localparam int LAT = 2;

  logic        P_clk = 1'b0;
  logic        P_rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [39:0] req_addr;
  logic [7:0]  req_len;
  logic        cyc_valid;
  logic [1:0]  cyc_type;
  logic [7:0]  cyc_byte;
  logic        cyc_done;
  logic [7:0]  cyc_rdata;
  logic [7:0]  wr_data;
  logic        wr_valid, wr_pop;
  logic [7:0]  rd_data;
  logic        rd_push, rd_ready;
  logic        F_nRB;
  logic        busy, op_done;
  logic [1:0]  op_status;
  logic [7:0]  flash_status;

  always #5 P_clk = ~P_clk;

  nand_op_sequencer #(.TWB_CYC(TWB), .TIMEOUT_CYC(TMO), .TO_W(16)) dut (
    .P_clk(P_clk), .P_rst(P_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_len(req_len),
    .cyc_valid(cyc_valid), .cyc_type(cyc_type), .cyc_byte(cyc_byte),
    .cyc_done(cyc_done), .cyc_rdata(cyc_rdata),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_pop(wr_pop),
    .rd_data(rd_data), .rd_push(rd_push), .rd_ready(rd_ready),
    .F_nRB(F_nRB), .busy(busy), .op_done(op_done),
    .op_status(op_status), .flash_status(flash_status)
  );

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_cyc_q[$];
  logic [7:0] eng_rd_q[$];
  logic [7:0] exp_push_q[$];
  logic [7:0] tx_q[$];

  int   cyc_n = 0, eng_cnt = 0, busy_cnt = 0, busy_len = 10, stall_cnt = 0;
  int   pops = 0, pushes = 0, done_cnt = 0, t_last_cmd = 0, t_op_done = 0;
  bit   busy_hold = 0, stall_on_pop = 0;
  logic [1:0] first_t;
  logic [7:0] first_b;

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc_n);
    end
  endtask

  // Engine, FIFO and flash models, all advanced on the falling edge.
  always @(negedge P_clk) begin
    cyc_n++;
    if (P_rst) begin
      eng_cnt  = 0;
      cyc_done = 1'b0;
    end else begin
      if (!busy_hold && busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) F_nRB = 1'b1;
      end
      if (cyc_done) begin
        cyc_done = 1'b0;
        check_eq("gap_after_done", cyc_valid, 1'b0);
      end else if (cyc_valid) begin
        if (eng_cnt == 0) begin
          first_t = cyc_type;
          first_b = cyc_byte;
        end
        eng_cnt++;
        if (eng_cnt == LAT) begin
          eng_cnt = 0;
          check_eq("cyc_hold", {cyc_type, cyc_byte}, {first_t, first_b});
          check_eq("cyc", {cyc_type, cyc_byte},
                   (exp_cyc_q.size() != 0) ? exp_cyc_q.pop_front() : 10'h3FF);
          cyc_done  = 1'b1;
          cyc_rdata = (cyc_type == CYC_RDATA && eng_rd_q.size() != 0) ? eng_rd_q.pop_front() : 8'h00;
          if (cyc_type == CYC_CMD && cyc_byte inside {8'h30, 8'h10, 8'hD0, 8'hFF}) begin
            F_nRB      = 1'b0;
            busy_cnt   = busy_len;
            t_last_cmd = cyc_n;
          end
        end
      end
    end
    wr_valid = (tx_q.size() != 0) && (stall_cnt == 0);
    wr_data  = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
    if (stall_cnt > 0) begin
      check_eq("stall_no_cyc", cyc_valid, 1'b0);
      stall_cnt--;
    end
    #1;
    if (wr_pop) begin
      pops++;
      if (tx_q.size() != 0) void'(tx_q.pop_front());
      if (stall_on_pop) begin
        stall_on_pop = 0;
        stall_cnt    = 5;
      end
      wr_valid = (tx_q.size() != 0) && (stall_cnt == 0);
      wr_data  = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
    end
    if (rd_push) begin
      pushes++;
      check_eq("rd_data", {1'b0, rd_data},
               (exp_push_q.size() != 0) ? {1'b0, exp_push_q.pop_front()} : 9'h100);
    end
    if (op_done) begin
      done_cnt++;
      t_op_done = cyc_n;
    end
  end

  task automatic exp_cyc(input cyc_e t, input logic [7:0] b);
    exp_cyc_q.push_back({t, b});
  endtask

  task automatic exp_addr(input logic [39:0] a, input int first);
    for (int i = first; i < 5; i++) exp_cyc(CYC_ADDR, a[i*8 +: 8]);
  endtask

  task automatic start_op(input op_e op, input logic [39:0] a, input logic [7:0] len);
    for (int n = 0; n < 100 && !req_ready; n++) @(negedge P_clk);
    req_op    = op;
    req_addr  = a;
    req_len   = len;
    req_valid = 1'b1;
    @(negedge P_clk);
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_addr  = {8'($urandom), 32'($urandom)};
    req_len   = 8'($urandom);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    start = done_cnt;
    for (int n = 0; n < budget && done_cnt == start; n++) begin
      @(negedge P_clk);
      #2;
    end
    check_eq({tag, "_op_done"}, done_cnt - start, 1);
  endtask

  task automatic finish_op(input string tag, input status_e st);
    check_eq({tag, "_status"}, op_status, st);
    check_eq({tag, "_cyc_left"}, exp_cyc_q.size(), 0);
    @(negedge P_clk);
    #2;
    check_eq({tag, "_ready_after"}, {req_ready, op_done}, 2'b10);
  endtask

  initial begin
    P_rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = '0; req_len = '0;
    cyc_done = 1'b0; cyc_rdata = 8'h00; wr_data = 8'h00; wr_valid = 1'b0;
    rd_ready = 1'b1; F_nRB = 1'b1;
    repeat (3) @(negedge P_clk);
    #2;
    check_eq("rst_req_ready", req_ready, 1'b1);
    check_eq("rst_ctrl", {busy, cyc_valid, wr_pop, rd_push, op_done}, 5'b0);
    check_eq("rst_cyc", {cyc_type, cyc_byte}, 10'h000);
    check_eq("rst_status", {rd_data, op_status, flash_status}, 18'h0);
    P_rst = 1'b0;

    // READ, three data bytes
    exp_cyc(CYC_CMD, 8'h00);
    exp_addr(40'h04_0302_0100, 0);
    exp_cyc(CYC_CMD, 8'h30);
    for (int i = 0; i < 3; i++) begin
      exp_cyc(CYC_RDATA, 8'h00);
      eng_rd_q.push_back(8'hA1 + 8'(i * 17));
      exp_push_q.push_back(8'hA1 + 8'(i * 17));
    end
    busy_len = 10;
    pushes   = 0;
    start_op(OP_READ, 40'h04_0302_0100, 8'd3);
    wait_done("read3", 500);
    check_eq("read3_pushes", pushes, 3);
    finish_op("read3", ST_OK);

    // PROGRAM, two bytes with a Tx stall after the first, status FAIL
    exp_cyc(CYC_CMD, 8'h80);
    exp_addr(40'h00_0012_3456, 0);
    exp_cyc(CYC_WDATA, 8'h5A);
    exp_cyc(CYC_WDATA, 8'hC3);
    exp_cyc(CYC_CMD, 8'h10);
    exp_cyc(CYC_CMD, 8'h70);
    exp_cyc(CYC_RDATA, 8'h00);
    eng_rd_q.push_back(8'h01);
    tx_q.push_back(8'h5A);
    tx_q.push_back(8'hC3);
    stall_on_pop = 1;
    pops = 0;
    pushes = 0;
    start_op(OP_PROGRAM, 40'h00_0012_3456, 8'd2);
    wait_done("prog", 500);
    check_eq("prog_flash_status", flash_status, 8'h01);
    check_eq("prog_pops", pops, 2);
    check_eq("prog_no_push", pushes, 0);
    finish_op("prog", ST_FAIL);

    // ERASE, row bytes only, 100-cycle busy
    exp_cyc(CYC_CMD, 8'h60);
    exp_addr(40'hCC_BBAA_0000, 2);
    exp_cyc(CYC_CMD, 8'hD0);
    exp_cyc(CYC_CMD, 8'h70);
    exp_cyc(CYC_RDATA, 8'h00);
    eng_rd_q.push_back(8'hE0);
    busy_len = 100;
    start_op(OP_ERASE, 40'hCC_BBAA_0000, 8'd0);
    wait_done("erase", 800);
    check_eq("erase_flash_status", flash_status, 8'hE0);
    finish_op("erase", ST_OK);

    // RESET with R/B# stuck low
    exp_cyc(CYC_CMD, 8'hFF);
    busy_hold = 1;
    start_op(OP_RESET, 40'h0, 8'd0);
    wait_done("reset_to", TMO + 200);
    check_eq("reset_to_latency", t_op_done - t_last_cmd, TWB + TMO);
    check_eq("reset_to_flash_status", flash_status, 8'hE0);
    finish_op("reset_to", ST_TIMEOUT);
    busy_hold = 0;
    busy_cnt  = 0;
    F_nRB     = 1'b1;

    // Synchronous reset while the second address cycle is outstanding
    exp_cyc(CYC_CMD, 8'h00);
    exp_addr(40'h55_4433_2211, 0);
    busy_len = 10;
    begin
      int start;
      bit hit;
      start = done_cnt;
      hit   = 0;
      start_op(OP_READ, 40'h55_4433_2211, 8'd4);
      for (int n = 0; n < 50 && !hit; n++) begin
        @(negedge P_clk);
        #2;
        hit = cyc_valid && (cyc_byte == 8'h22) && (exp_cyc_q.size() == 4);
      end
      check_eq("mid_rst_reached", hit, 1'b1);
      #1;
      P_rst = 1'b1;
      @(negedge P_clk);
      #2;
      check_eq("mid_rst_idle", {cyc_valid, req_ready, busy, op_done}, 4'b0100);
      P_rst = 1'b0;
      exp_cyc_q.delete();
      repeat (10) @(negedge P_clk);
      #2;
      check_eq("mid_rst_no_done", done_cnt - start, 0);
      check_eq("mid_rst_no_cyc", cyc_valid, 1'b0);
    end

    // READ with zero length
    exp_cyc(CYC_CMD, 8'h00);
    exp_addr(40'h0A_0B0C_0D0E, 0);
    exp_cyc(CYC_CMD, 8'h30);
    pushes = 0;
    start_op(OP_READ, 40'h0A_0B0C_0D0E, 8'd0);
    wait_done("read0", 500);
    check_eq("read0_pushes", pushes, 0);
    finish_op("read0", ST_OK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nand_op_sequencer.md
# nand_op_sequencer

Operation-level sequencer sitting between the APB register/FIFO front end and the NAND flash-cycle engine. Accepts one READ, PROGRAM, ERASE or RESET request at a time. Expands it into the ordered command, address and data byte cycles the engine drives onto the flash pins. Waits on the flash ready/busy line with a timeout, and reports completion status.

## Interface
- `TWB_CYC`, 4: cycles waited after the last command byte before `F_nRB` is sampled (covers tWB).
- `TIMEOUT_CYC`, 50000: maximum cycles spent in busy-wait before aborting.
- `TO_W`, 16: width of the timeout counter; must satisfy TIMEOUT_CYC < 2^TO_W.
- `P_clk` in 1: sole clock.
- `P_rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: operation request.
- `req_ready` out 1: high only in IDLE; transfer when both high.
- `req_op` in 2: 0 READ, 1 PROGRAM, 2 ERASE, 3 RESET.
- `req_addr` in 40: 5 address bytes; byte 0 = [7:0] is sent first.
- `req_len` in 8: number of data bytes for READ/PROGRAM; 0 is legal.
- `cyc_valid` out 1: cycle request to the engine; held until `cyc_done`.
- `cyc_type` out 2: 0 CMD, 1 ADDR, 2 WDATA, 3 RDATA.
- `cyc_byte` out 8: command/address/write byte; 0 for RDATA.
- `cyc_done` in 1: one-cycle pulse from the engine when the cycle completes.
- `cyc_rdata` in 8: read byte, valid with `cyc_done` on RDATA cycles.
- `wr_data` in 8, `wr_valid` in 1: Tx FIFO head.
- `wr_pop` out 1: one-cycle pulse on `cyc_done` of each WDATA cycle.
- `rd_data` out 8, `rd_push` out 1: to Rx FIFO; push pulses with `cyc_done` of each data RDATA cycle.
- `rd_ready` in 1: Rx FIFO not full.
- `F_nRB` in 1: asynchronous flash ready/busy, low = busy.
- `busy` out 1: high whenever state ≠ IDLE.
- `op_done` out 1: one-cycle completion pulse.
- `op_status` out 2: 0 OK, 1 FAIL, 2 TIMEOUT; held until the next `op_done`.
- `flash_status` out 8: last byte read by the 0x70 status read; held.

## Operation
- Byte sequences:
  - READ: CMD 00, ADDR b0..b4, CMD 30, busy-wait, RDATA ×len.
  - PROGRAM: CMD 80, ADDR b0..b4, WDATA ×len, CMD 10, busy-wait, CMD 70, RDATA ×1 (status).
  - ERASE: CMD 60, ADDR b2..b4, CMD D0, busy-wait, CMD 70, RDATA ×1.
  - RESET: CMD FF, busy-wait.
- States: IDLE, CMD1, ADDR, WDATA, CMD2, TWB, WAIT_RB, STAT_CMD, STAT_RD, RDATA, DONE.
- Request capture: `req_op`, `req_addr` and `req_len` are registered at acceptance; inputs are ignored afterwards.
- Byte indexing: 3-bit address index; 8-bit data counter counting down. When len = 0, the data state is skipped with no cycle issued.
- WDATA flow control: a WDATA cycle is issued only while `wr_valid` is high; otherwise `cyc_valid` stays low (stall, no timeout).
- RDATA flow control: a data RDATA cycle is issued only while `rd_ready` is high.
- `F_nRB` synchronisation: through a 2-flop synchroniser; all uses below refer to the synchronised value.
- TWB: counts TWB_CYC cycles, then moves to WAIT_RB.
- WAIT_RB: leaves when the synchronised `F_nRB` = 1. The timeout counter starts at 0 on entry; reaching TIMEOUT_CYC−1 moves to DONE with TIMEOUT, skipping the status read and remaining data.
- Status: for PROGRAM/ERASE, `flash_status` is set to `cyc_rdata`; FAIL if bit0 = 1, else OK. READ and RESET complete OK unless timed out.
- Reset mid-operation: the next cycle is IDLE with `cyc_valid` = 0; no completion pulse. A `cyc_done` arriving while IDLE is ignored.

## Timing
- Reset values:
  - `req_ready` = 1.
  - `busy`, `cyc_valid`, `wr_pop`, `rd_push` and `op_done` = 0.
  - `cyc_type`, `cyc_byte`, `rd_data`, `op_status` and `flash_status` = 0.
- Acceptance: `cyc_valid` rises the cycle after acceptance (first CMD).
- Handshake: `cyc_valid`, `cyc_type` and `cyc_byte` are stable from assertion until the `cyc_done` cycle inclusive. `cyc_valid` is low for exactly one cycle after each `cyc_done` before the next request.
- Busy-wait: `F_nRB` is first sampled TWB_CYC cycles after the last command's `cyc_done`. Synchroniser latency adds 2 cycles to detecting ready.
- Completion: DONE lasts one cycle with `op_done` = 1; `req_ready` rises the following cycle. A back-to-back request is accepted that cycle.
- Status: `op_status` and `flash_status` update in the DONE cycle.

## Structure
- Package `nand_seq_pkg`: op encodings, cycle-type encodings, NAND command bytes (00, 30, 80, 10, 60, D0, 70, FF), status codes, state enum.
- Sub-module `nand_rb_sync`: 2-flop `F_nRB` synchroniser plus TWB and timeout counters, with outputs `rb_ready` and `rb_timeout`.

## Test plan
- READ, addr 0x0403020100, len 3, engine responds `cyc_done` after 2 cycles: cycles CMD00, ADDR 00..04, CMD30, RDATA×3. Three `rd_push` with engine data; `op_status` 0.
- PROGRAM, len 2, `wr_valid` dropped for 5 cycles mid-data: WDATA stalls with no `cyc_valid`, then CMD10, CMD70, status 0x01. Exactly 2 `wr_pop`; `op_status` = FAIL; `flash_status` = 0x01.
- ERASE, addr 0xCCBBAA0000: ADDR bytes AA, BB, CC only; busy for 100 cycles; `op_status` OK.
- RESET with `F_nRB` held low: `op_done` with TIMEOUT exactly TWB_CYC + TIMEOUT_CYC cycles after the FF `cyc_done`; no status read.
- READ len 0: no RDATA cycles, OK.
- `P_rst` during ADDR cycle 2: next cycle IDLE, `cyc_valid` = 0, `req_ready` = 1, no `op_done`.
